// File: rtl/sram_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_pkg
// Shared definitions for the SRAM bus arbiter: FSM state encodings, bus size
// codes, owner encoding and the width of the stall-request pair that is folded
// into the pipeline stall bus.
// -----------------------------------------------------------------------------
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // {stallreq_mem, stallreq_if}
  localparam int STALL_W = 2;

  // A requester stalls its stage while it holds req and has not yet seen done.
  // rst_n forces the request low while the arbiter is in reset.
  function automatic logic stall_req(input logic req, input logic done, input logic rst_n);
    return req & ~done & rst_n;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_if
// Bundles the IF/MEM requester handshakes, the external memory bus and the
// stall requests.
//   slave  : arbiter view (requests and bus responses in, bus fields, done
//            pulses, read data and stalls out)
//   master : environment view (requesters plus memory), the mirror image
// -----------------------------------------------------------------------------
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction-fetch requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_done;

  // Data (load/store) requester
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_done;

  // External memory bus
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  // Stall requests toward the pipeline stall controller
  logic              stallreq_if;
  logic              stallreq_mem;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_done, data_rdata, data_done,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output stallreq_if, stallreq_mem
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_done, data_rdata, data_done,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  stallreq_if, stallreq_mem
  );

endinterface

// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
// Shares one SRAM-like bus between instruction fetch and data access, one
// outstanding transaction at a time, data having priority.
// Ports:
//   clk    : clock
//   rst    : synchronous active-low reset
//   bus_if : sram_bus_arbiter_if.slave (requesters, memory bus, stall requests)
// Flow: IDLE --grant--> REQ --addr_ok--> WAIT --data_ok--> IDLE (done pulse).
// -----------------------------------------------------------------------------
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  sram_bus_arbiter_if.slave  bus_if
);

  state_e            state_q;
  owner_e            owner_q;
  logic              bus_req_q;
  logic              bus_wr_q;
  logic [1:0]        bus_size_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              inst_done_q;
  logic              data_done_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;

  // The done mask stops a requester that still holds req during its
  // completion cycle from being granted a second time.
  logic inst_elig_s;
  logic data_elig_s;
  assign inst_elig_s = bus_if.inst_req & ~inst_done_q;
  assign data_elig_s = bus_if.data_req & ~data_done_q;

  // Arbitration FSM with all bus fields, done pulses and read data registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'd0;
      bus_addr_q   <= {ADDR_W{1'b0}};
      bus_wdata_q  <= {DATA_W{1'b0}};
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= {DATA_W{1'b0}};
      data_rdata_q <= {DATA_W{1'b0}};
    end else begin
      // Done is a single-cycle pulse unless WAIT completes below.
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (data_elig_s) begin
            owner_q     <= OWN_DATA;
            bus_wr_q    <= bus_if.data_wr;
            bus_size_q  <= bus_if.data_size;
            bus_addr_q  <= bus_if.data_addr;
            bus_wdata_q <= bus_if.data_wdata;
            bus_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end else if (inst_elig_s) begin
            owner_q     <= OWN_INST;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= SIZE_WORD;
            bus_addr_q  <= bus_if.inst_addr;
            bus_wdata_q <= {DATA_W{1'b0}};
            bus_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_if.bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_WAIT;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus_if.bus_data_ok) begin
            if (owner_q == OWN_DATA) begin
              data_rdata_q <= bus_if.bus_rdata;
              data_done_q  <= 1'b1;
            end else begin
              inst_rdata_q <= bus_if.bus_rdata;
              inst_done_q  <= 1'b1;
            end
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_if.bus_req      = bus_req_q;
  assign bus_if.bus_wr       = bus_wr_q;
  assign bus_if.bus_size     = bus_size_q;
  assign bus_if.bus_addr     = bus_addr_q;
  assign bus_if.bus_wdata    = bus_wdata_q;
  assign bus_if.inst_done    = inst_done_q;
  assign bus_if.data_done    = data_done_q;
  assign bus_if.inst_rdata   = inst_rdata_q;
  assign bus_if.data_rdata   = data_rdata_q;
  assign bus_if.stallreq_if  = stall_req(bus_if.inst_req, inst_done_q, rst);
  assign bus_if.stallreq_mem = stall_req(bus_if.data_req, data_done_q, rst);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Directed bench for sram_bus_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0000;
    ifc.data_req = 1'b0; ifc.data_wr = 1'b0; ifc.data_size = 2'd0;
    ifc.data_addr = 32'h0; ifc.data_wdata = 32'h0;
    ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    tick(); tick();
    n_checks++; if (ifc.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %0h want 0", ifc.bus_req); end
    n_checks++; if (ifc.bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %0h want 0", ifc.bus_addr); end
    n_checks++; if (ifc.inst_done !== 1'b0) begin n_fail++; $display("FAIL reset_inst_done: got %0h want 0", ifc.inst_done); end
    n_checks++; if (ifc.inst_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_inst_rdata: got %0h want 0", ifc.inst_rdata); end
    n_checks++; if (ifc.stallreq_if !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq_if: got %0h want 0", ifc.stallreq_if); end
    rst = 1'b1;
    tick();
    n_checks++; if (ifc.bus_req !== 1'b1) begin n_fail++; $display("FAIL release_bus_req: got %0h want 1", ifc.bus_req); end
    n_checks++; if (ifc.bus_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL release_bus_addr: got %0h want bfc00000", ifc.bus_addr); end
    n_checks++; if (ifc.bus_size !== 2'd2 || ifc.bus_wr !== 1'b0) begin n_fail++; $display("FAIL release_fetch_fields: got size %0h wr %0h want size 2 wr 0", ifc.bus_size, ifc.bus_wr); end
    n_checks++; if (ifc.stallreq_if !== 1'b1) begin n_fail++; $display("FAIL release_stallreq_if: got %0h want 1", ifc.stallreq_if); end
  endtask

  // Continues the fetch granted on reset release (arbiter is in REQ).
  task automatic test_single_fetch();
    ifc.bus_addr_ok = 1'b1;
    tick();
    ifc.bus_addr_ok = 1'b0;
    n_checks++; if (ifc.bus_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_drop: got %0h want 0", ifc.bus_req); end
    tick();
    n_checks++; if (ifc.inst_done !== 1'b0) begin n_fail++; $display("FAIL fetch_early_done: got %0h want 0", ifc.inst_done); end
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h3C08_0001;
    tick();
    ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    n_checks++; if (ifc.inst_done !== 1'b1) begin n_fail++; $display("FAIL fetch_done: got %0h want 1", ifc.inst_done); end
    n_checks++; if (ifc.inst_rdata !== 32'h3C08_0001) begin n_fail++; $display("FAIL fetch_rdata: got %0h want 3c080001", ifc.inst_rdata); end
    n_checks++; if (ifc.stallreq_if !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_drop: got %0h want 0", ifc.stallreq_if); end
    ifc.inst_req = 1'b0;
    tick();
    n_checks++; if (ifc.inst_done !== 1'b0) begin n_fail++; $display("FAIL fetch_done_pulse: got %0h want 0", ifc.inst_done); end
    n_checks++; if (ifc.inst_rdata !== 32'h3C08_0001) begin n_fail++; $display("FAIL fetch_rdata_hold: got %0h want 3c080001", ifc.inst_rdata); end
    n_checks++; if (ifc.bus_req !== 1'b0) begin n_fail++; $display("FAIL fetch_no_regrant: got %0h want 0", ifc.bus_req); end
  endtask

  task automatic test_contention();
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'h0040_0000;
    ifc.data_req = 1'b1; ifc.data_wr = 1'b0; ifc.data_size = 2'd2;
    ifc.data_addr = 32'h8000_1000; ifc.data_wdata = 32'h0;
    tick();
    n_checks++; if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL cont_data_first: got req %0h addr %0h want 1 80001000", ifc.bus_req, ifc.bus_addr); end
    n_checks++; if (ifc.stallreq_if !== 1'b1 || ifc.stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL cont_stalls: got if %0h mem %0h want 1 1", ifc.stallreq_if, ifc.stallreq_mem); end
    ifc.bus_addr_ok = 1'b1;
    tick();
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h1122_3344;
    tick();
    ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    n_checks++; if (ifc.data_done !== 1'b1 || ifc.inst_done !== 1'b0) begin n_fail++; $display("FAIL cont_data_done: got data %0h inst %0h want 1 0", ifc.data_done, ifc.inst_done); end
    n_checks++; if (ifc.data_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL cont_data_rdata: got %0h want 11223344", ifc.data_rdata); end
    n_checks++; if (ifc.stallreq_if !== 1'b1 || ifc.stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL cont_done_stalls: got if %0h mem %0h want 1 0", ifc.stallreq_if, ifc.stallreq_mem); end
    ifc.data_req = 1'b0;
    tick();
    n_checks++; if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL cont_inst_grant: got req %0h addr %0h want 1 400000", ifc.bus_req, ifc.bus_addr); end
    n_checks++; if (ifc.bus_size !== 2'd2 || ifc.bus_wr !== 1'b0) begin n_fail++; $display("FAIL cont_inst_fields: got size %0h wr %0h want 2 0", ifc.bus_size, ifc.bus_wr); end
    n_checks++; if (ifc.stallreq_if !== 1'b1) begin n_fail++; $display("FAIL cont_if_still_stalled: got %0h want 1", ifc.stallreq_if); end
    ifc.bus_addr_ok = 1'b1;
    tick();
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hDEAD_BEEF;
    tick();
    ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    n_checks++; if (ifc.inst_done !== 1'b1 || ifc.inst_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cont_inst_done: got done %0h rdata %0h want 1 deadbeef", ifc.inst_done, ifc.inst_rdata); end
    n_checks++; if (ifc.data_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL cont_data_rdata_hold: got %0h want 11223344", ifc.data_rdata); end
    ifc.inst_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd0;
    ifc.data_addr = 32'h8000_0003; ifc.data_wdata = 32'h0000_00AB;
    tick();
    // addr_ok held off for three cycles: fields must not move.
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ifc.bus_req !== 1'b1 || ifc.bus_wr !== 1'b1 || ifc.bus_size !== 2'd0 ||
          ifc.bus_addr !== 32'h8000_0003 || ifc.bus_wdata !== 32'h0000_00AB) begin
        n_fail++;
        $display("FAIL store_hold_%0d: got req %0h wr %0h size %0h addr %0h wdata %0h want 1 1 0 80000003 ab",
                 i, ifc.bus_req, ifc.bus_wr, ifc.bus_size, ifc.bus_addr, ifc.bus_wdata);
      end
      if (i == 2) ifc.bus_addr_ok = 1'b1;
      tick();
    end
    ifc.bus_addr_ok = 1'b0;
    n_checks++; if (ifc.bus_req !== 1'b0) begin n_fail++; $display("FAIL store_req_drop: got %0h want 0", ifc.bus_req); end
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h0000_0055;
    tick();
    ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    n_checks++; if (ifc.data_done !== 1'b1 || ifc.data_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL store_done: got done %0h rdata %0h want 1 55", ifc.data_done, ifc.data_rdata); end
    ifc.data_req = 1'b0; ifc.data_wr = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    ifc.data_req = 1'b1; ifc.data_wr = 1'b0; ifc.data_size = 2'd2;
    ifc.data_addr = 32'h8000_3000; ifc.data_wdata = 32'h0;
    tick();
    ifc.bus_addr_ok = 1'b1;
    tick();
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h0BAD_F00D;
    tick();
    ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    n_checks++; if (ifc.data_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %0h want 1", ifc.data_done); end
    // req stays high through the done cycle; new fields for the next access.
    ifc.data_addr = 32'h8000_3004; ifc.data_size = 2'd1;
    tick();
    n_checks++; if (ifc.bus_req !== 1'b0 || ifc.data_done !== 1'b0) begin n_fail++; $display("FAIL b2b_masked: got req %0h done %0h want 0 0", ifc.bus_req, ifc.data_done); end
    n_checks++; if (ifc.stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %0h want 1", ifc.stallreq_mem); end
    tick();
    n_checks++; if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h8000_3004 || ifc.bus_size !== 2'd1) begin n_fail++; $display("FAIL b2b_regrant: got req %0h addr %0h size %0h want 1 80003004 1", ifc.bus_req, ifc.bus_addr, ifc.bus_size); end
  endtask

  // Continues from the REQ left by test_back_to_back.
  task automatic test_reset_mid_op();
    ifc.bus_addr_ok = 1'b1;
    tick();
    ifc.bus_addr_ok = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++; if (ifc.bus_req !== 1'b0 || ifc.data_done !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got req %0h done %0h want 0 0", ifc.bus_req, ifc.data_done); end
    n_checks++; if (ifc.stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %0h want 0", ifc.stallreq_mem); end
    n_checks++; if (ifc.data_rdata !== 32'h0 || ifc.inst_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got data %0h inst %0h want 0 0", ifc.data_rdata, ifc.inst_rdata); end
    rst = 1'b1; ifc.data_req = 1'b0;
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hCAFE_0001;
    tick();
    ifc.bus_data_ok = 1'b0; ifc.bus_rdata = 32'h0;
    n_checks++; if (ifc.data_done !== 1'b0 || ifc.inst_done !== 1'b0) begin n_fail++; $display("FAIL midrst_late_ok_done: got data %0h inst %0h want 0 0", ifc.data_done, ifc.inst_done); end
    n_checks++; if (ifc.data_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_late_ok_rdata: got %0h want 0", ifc.data_rdata); end
    tick();
    n_checks++; if (ifc.bus_req !== 1'b0 || ifc.data_done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got req %0h done %0h want 0 0", ifc.bus_req, ifc.data_done); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch requester (IF) and the data-access requester (MEM load/store).
- Supports one outstanding transaction at a time. Data requests have priority.
- Raises per-stage stall requests toward the pipeline stall controller while a requester waits.
- Sits between the IF/MEM stages and the external memory interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low (0 = reset)
inst_req  in  1  IF request; held high with stable fields until inst_done
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word, valid while inst_done=1
inst_done  out  1  one-cycle completion pulse
data_req  in  1  MEM request; held high with stable fields until data_done
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data, valid while data_done=1
data_done  out  1  one-cycle completion pulse
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  address accepted (handshake with bus_req)
bus_data_ok  in  1  transaction complete
bus_rdata  in  DATA_W  read data, valid with bus_data_ok
stallreq_if  out  1  IF stall request
stallreq_mem  out  1  MEM stall request

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - bus_req, bus_wr, bus_size, bus_addr, bus_wdata all 0.
  - inst_done=data_done=0; inst_rdata=data_rdata=0; owner=INST.
  - Any in-flight bus transaction is abandoned. The memory side is reset by the same rst.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Eligible requester = req high AND its own done low. The done mask blocks re-granting a requester during its completion cycle, when its req is still high.
  - If data is eligible, grant data. Otherwise, if inst is eligible, grant inst (inst fetch uses wr=0, size=2).
  - On grant: latch owner, wr, size, addr, wdata into bus_* registers, set bus_req=1, go to REQ.
  - Latency: bus_req rises in the cycle after req is first sampled.
- REQ:
  - Hold bus_req and fields stable.
  - On bus_addr_ok=1: bus_req<=0, go to WAIT.
- WAIT:
  - On bus_data_ok=1: capture bus_rdata into the owner's rdata register (stores capture as-is; value unused), pulse the owner's done for exactly one cycle (registered), go to IDLE.
  - bus_data_ok outside WAIT is ignored. The bus guarantees data_ok no earlier than the cycle after addr_ok.
- rdata registers hold their value until the next completion for the same owner.
- Minimum turnaround:
  - req sampled (N), bus_req (N+1), addr_ok (N+1), data_ok (N+2), done (N+3).
  - The next grant can issue in the done cycle N+3 to the other requester only.
- Simultaneous inst_req and data_req in IDLE: data wins; inst waits (stallreq_if stays high).
- Stall outputs, combinational:
  - stallreq_if = inst_req & ~inst_done
  - stallreq_mem = data_req & ~data_done
  - Both are 0 during reset.
- A requester dropping req before its done is a protocol violation. The arbiter completes the transaction and pulses done anyway.
- No address decoding, alignment checks or byte-lane generation: those stay in the requesting stage.

Decomposition:
- Shared defines header holds:
  - state encodings (IDLE/REQ/WAIT)
  - size codes (BYTE/HALF/WORD)
  - owner encoding (INST/DATA)
  - total width of the stall-request pair, to fold into the existing stall bus
- Single module; no sub-module is natural. The FSM plus latch registers are under 200 lines.

Test Plan:
- Reset: hold rst=0 two cycles with inst_req=1 -> bus_req=0, inst_done=0, inst_rdata=0, stallreq_if=0; release -> bus_req=1 the cycle after release with bus_addr=inst_addr.
- Single fetch: inst_req=1, addr=0xBFC00000; addr_ok the next cycle; data_ok 2 cycles later with rdata=0x3C080001 -> inst_done pulses once, inst_rdata=0x3C080001, stallreq_if drops in that cycle.
- Contention: inst_req and data_req (load, addr=0x80001000, size=2) rise together -> data granted first (bus_addr=0x80001000); inst granted in the data_done cycle; stallreq_if stays high throughout.
- Store: data_req, wr=1, size=0, addr=0x80000003, wdata=0x000000AB -> bus_wr=1, bus_size=0, bus_wdata=0xAB held until addr_ok; addr_ok delayed 3 cycles -> fields stable all 3 cycles.
- Back-to-back: data_req held high through its done cycle -> no second grant in the done cycle; a new request the following cycle is granted normally.
- Reset mid-operation: rst=0 while in WAIT -> next cycle IDLE, data_done never pulses, a late bus_data_ok is ignored.
